// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode and control-field encodings for the multi-cycle MIPS control
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational state to control-word decoder (Moore, plus mem_ready gating in FETCH)
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        // IR and PC only commit once the fetch has actually returned
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
      S_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM with retired-instruction counter
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_t           state;
  state_t           state_next;
  logic             is_sw;
  logic             retire;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl_raw;
  ctrl_t            ctrl;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FETCH;
      retired_q <= '0;
      is_sw     <= 1'b0;
    end else begin
      state <= state_next;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      // MEMADR picks load vs store from this, so IR changes after DECODE cannot misroute it
      if (state == S_DECODE) is_sw <= (opcode == OP_SW);
    end
  end

  always_comb begin
    state_next = S_FETCH;
    retire     = 1'b0;
    case (state)
      S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_next = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        state_next = mem_ready ? S_FETCH : S_MEMWR;
        retire     = mem_ready;
      end
      S_EXEC:    state_next = S_ALUWB;
      S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_ADDIEX:  state_next = S_ADDIWB;
      S_ILLEGAL: state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  ctrl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_raw)
  );

  assign ctrl       = reset ? '0 : ctrl_raw;
  assign pc_en      = ctrl.pc_write | (ctrl.pc_write_cond & zero);
  assign pc_source  = ctrl.pc_source;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign illegal_op = ctrl.illegal_op;
  assign state_o    = state;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control using directed instruction vectors
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } obs_t;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] ret;
    obs_t       ctl;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state_o;
  logic [3:0] retired;

  int    tests  = 0;
  int    failed = 0;
  exp_t  exp_q[$];
  string name_q[$];

  multicycle_control #(.CNT_W(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_op(illegal_op), .state_o(state_o), .retired(retired)
  );

  always #5 clock = ~clock;

  // Expected control outputs per state, written from the state table
  function automatic obs_t ref_ctl(input logic [3:0] st, input logic mr, input logic z);
    obs_t o;
    o = '0;
    case (st)
      4'd0:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
      4'd1:  o.alu_src_b = 2'b11;
      4'd2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      4'd3:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
      4'd4:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
      4'd5:  begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
      4'd6:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      4'd7:  begin o.reg_dst = 1'b1; o.reg_write = 1'b1; end
      4'd8:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_en = z; end
      4'd9:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      4'd10: o.reg_write = 1'b1;
      4'd11: begin o.pc_en = 1'b1; o.pc_source = 2'b10; end
      4'd12: o.illegal_op = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic step(input logic rst, input logic [5:0] op, input logic z, input logic mr,
                      input logic [3:0] est, input logic [3:0] eret, input string nm);
    exp_t e;
    reset     = rst;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    e.st  = est;
    e.ret = eret;
    e.ctl = rst ? obs_t'('0) : ref_ctl(est, mr, z);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.st  = state_o;
      a.ret = retired;
      a.ctl = {pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op};
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL %s: got state=%0d retired=%0d ctrl=%h, expected state=%0d retired=%0d ctrl=%h",
                 nm, a.st, a.ret, a.ctl, e.st, e.ret, e.ctl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = OP_LW; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clock); #1;
    step(1, OP_LW, 0, 1, 0, 0, "reset_hold0");
    step(1, OP_LW, 0, 1, 0, 0, "reset_hold1");
    // lw, 5 cycles
    step(0, OP_LW, 0, 1, 0, 0, "lw_fetch");
    step(0, OP_LW, 0, 1, 1, 0, "lw_decode");
    step(0, OP_LW, 0, 1, 2, 0, "lw_memadr");
    step(0, OP_LW, 0, 1, 3, 0, "lw_memrd");
    step(0, OP_LW, 0, 1, 4, 0, "lw_memwb");
    // sw with a stalled fetch and 3 wait cycles in MEMWR
    step(0, OP_SW, 0, 0, 0, 1, "sw_fetch_wait");
    step(0, OP_SW, 0, 1, 0, 1, "sw_fetch");
    step(0, OP_SW, 0, 1, 1, 1, "sw_decode");
    step(0, OP_SW, 0, 1, 2, 1, "sw_memadr");
    step(0, OP_SW, 0, 0, 5, 1, "sw_memwr_wait0");
    step(0, OP_SW, 0, 0, 5, 1, "sw_memwr_wait1");
    step(0, OP_SW, 0, 0, 5, 1, "sw_memwr_wait2");
    step(0, OP_SW, 0, 1, 5, 1, "sw_memwr_done");
    // beq taken, then not taken
    step(0, OP_BEQ, 1, 1, 0, 2, "beq1_fetch");
    step(0, OP_BEQ, 1, 1, 1, 2, "beq1_decode");
    step(0, OP_BEQ, 1, 1, 8, 2, "beq1_branch");
    step(0, OP_BEQ, 0, 1, 0, 3, "beq0_fetch");
    step(0, OP_BEQ, 0, 1, 1, 3, "beq0_decode");
    step(0, OP_BEQ, 0, 1, 8, 3, "beq0_branch");
    // R-type and addi
    step(0, OP_RTYPE, 0, 1, 0, 4, "r_fetch");
    step(0, OP_RTYPE, 0, 1, 1, 4, "r_decode");
    step(0, OP_RTYPE, 0, 1, 6, 4, "r_exec");
    step(0, OP_RTYPE, 0, 1, 7, 4, "r_aluwb");
    step(0, OP_ADDI, 0, 1, 0, 5, "addi_fetch");
    step(0, OP_ADDI, 0, 1, 1, 5, "addi_decode");
    step(0, OP_ADDI, 0, 1, 9, 5, "addi_ex");
    step(0, OP_ADDI, 0, 1, 10, 5, "addi_wb");
    // illegal opcode: one-cycle pulse, not retired
    step(0, 6'b111111, 0, 1, 0, 6, "ill_fetch");
    step(0, 6'b111111, 0, 1, 1, 6, "ill_decode");
    step(0, 6'b111111, 0, 1, 12, 6, "ill_pulse");
    // lw interrupted by reset while stalled in MEMRD
    step(0, OP_LW, 0, 1, 0, 6, "abort_fetch");
    step(0, OP_LW, 0, 1, 1, 6, "abort_decode");
    step(0, OP_LW, 0, 1, 2, 6, "abort_memadr");
    step(0, OP_LW, 0, 0, 3, 6, "abort_memrd_wait");
    step(1, OP_LW, 0, 0, 3, 6, "abort_reset");
    // 16 jumps wrap the 4-bit counter back to 0
    for (int k = 0; k < 16; k++) begin
      step(0, OP_J, 0, 1, 0, 4'(k), "j_fetch");
      step(0, OP_J, 0, 1, 1, 4'(k), "j_decode");
      step(0, OP_J, 0, 1, 11, 4'(k), "j_jump");
    end
    step(0, OP_J, 0, 1, 0, 0, "j_wrap_fetch");
    @(negedge clock); #1;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main control FSM that sequences the MIPS datapath across FETCH/DECODE/EXECUTE/MEM/WB steps, replacing the single-cycle combinational main control.
- Drives the mux selects, write enables and ALU op class for a datapath that shares one memory between instruction fetch and data access.
- Waits on a memory-ready handshake, flags illegal opcodes and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high; sampled on the rising clock edge
opcode  in  6  IR[31:26] from the datapath instruction register
zero  in  1  ALU Zero flag
mem_ready  in  1  memory has completed the current read/write this cycle
pc_en  out  1  PC load enable = pc_write | (pc_write_cond & zero)
pc_source  out  2  00 ALU result, 01 ALUOut register (branch target), 10 jump target
i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  write register select: 0 rt, 1 rd
mem_to_reg  out  1  write-data select: 0 ALUOut, 1 MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0 PC, 1 register A
alu_src_b  out  2  00 register B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2
alu_op  out  2  00 add, 01 subtract, 10 decode funct (to ALU control)
illegal_op  out  1  one-cycle pulse on an unsupported opcode
state_o  out  4  current state (debug)
retired  out  CNT_W  count of completed instructions

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=12. Codes 13–15 are unreachable; if entered, go to FETCH.
- Reset: state←FETCH, retired←0. While reset=1, every output strobe/enable is forced 0. Reset mid-instruction, including MEMWR with a write pending, abandons it; the first post-reset cycle is FETCH.
- Outputs are Moore: decoded from state only, except the mem_ready gating listed below. Any signal not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=mem_ready; pc_write=mem_ready.
  - Hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. The opcode is sampled here to pick the next state:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - anything else → ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for lw, MEMWR for sw, using the opcode held from DECODE.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; then FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; then FETCH.
- JUMP: pc_write=1, pc_source=10; then FETCH.
- ILLEGAL: illegal_op=1 for exactly one cycle; then FETCH. The instruction is skipped (PC already advanced in FETCH) and is not counted as retired.
- Retired counter: increments by 1 on the transition out of MEMWB, MEMWR (with mem_ready=1), ALUWB, BRANCH, ADDIWB or JUMP. It wraps to 0 after all-ones.
- Latencies with mem_ready held high: lw=5 cycles, sw=4, R-type=4, addi=4, beq=3, j=3. Every mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encoding localparams;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - alu_op, alu_src_b and pc_source encodings, shared with ALU control and the datapath.
- One sub-module, ctrl_decode, is natural: a purely combinational state→control-word decoder, separating it from the next-state/counter logic.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1: state_o=0, all strobes 0 during reset, retired=0, then mem_read=1 and pc_en=1 in the first cycle after release.
- lw (opcode 100011), mem_ready=1: state_o sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4; retired goes 0→1.
- sw, with mem_ready=0 for 3 cycles in MEMWR: mem_write=1 held for 4 cycles, state stays 5, then FETCH; reg_write never asserted; retired+1.
- beq with zero=1, then beq with zero=0: pc_en=1 / pc_en=0 in BRANCH, pc_source=01, alu_op=01; each takes 3 cycles.
- Opcode 111111: DECODE→ILLEGAL; illegal_op pulses for 1 cycle; next state FETCH; retired unchanged.
- Reset asserted while in MEMRD with mem_ready=0: next state FETCH, mem_read=0 while reset=1, retired=0; preload retired to 2^CNT_W−1, execute j → retired wraps to 0.
